// File: rtl/irq_ctrl.sv
// Prioritised 8-source interrupt controller with MASK/PEND/STAT registers and an IDLE/REQ/SERV handshake FSM.
// Optional macro IRQ_CTRL_EDGE_EN selects edge-latched pending bits; the default build is level mode.
module irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_src,
    input  logic       iack,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_din,
    output logic [7:0] reg_dout,
    output logic       irq,
    output logic [2:0] irq_vec,
    output logic       irq_busy
);

    // state | meaning
    // IDLE  | nothing requested; waiting for an active (pending and unmasked) source
    // REQ   | irq asserted; waiting for an iack rising edge or for act to drop
    // SERV  | source irq_vec in service; waiting for the iack falling edge
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t     state;
    logic [7:0] mask;
    logic [7:0] pend;
    logic [7:0] act;
    logic [2:0] sel;
    logic       iack_d;
    logic       ack_rise;
    logic       ack_fall;

    assign act      = pend & mask;
    assign ack_rise = iack & ~iack_d;
    assign ack_fall = ~iack & iack_d;
    assign irq      = (state == REQ);

    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) sel = 3'(i);
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [7:0] src_d;
    logic [7:0] pend_q;
    logic [7:0] w1c;
    logic [7:0] ack_clr;
    logic       capture;

    assign capture = (state == REQ) && ack_rise && (act != 8'h00);
    assign w1c     = (reg_we && reg_addr == 2'd1) ? reg_din : 8'h00;
    assign ack_clr = capture ? (8'h01 << sel) : 8'h00;
    assign pend    = pend_q;

    // A new rising edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_d  <= 8'h00;
            pend_q <= 8'h00;
        end else begin
            src_d  <= irq_src;
            pend_q <= (pend_q & ~(w1c | ack_clr)) | (irq_src & ~src_d);
        end
    end
`else
    assign pend = irq_src;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask <= 8'h00;
        end else if (reg_we && reg_addr == 2'd0) begin
            mask <= reg_din;
        end
    end

    // Priority is resolved at the acknowledge edge, so late higher-priority arrivals win.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            iack_d   <= 1'b0;
            irq_vec  <= 3'd0;
            irq_busy <= 1'b0;
        end else begin
            iack_d <= iack;
            case (state)
                IDLE: begin
                    if (act != 8'h00) state <= REQ;
                end
                REQ: begin
                    if (act == 8'h00) begin
                        state <= IDLE;
                    end else if (ack_rise) begin
                        state    <= SERV;
                        irq_vec  <= sel;
                        irq_busy <= 1'b1;
                    end
                end
                SERV: begin
                    if (ack_fall) begin
                        state    <= IDLE;
                        irq_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_dout = 8'h00;
        case (reg_addr)
            2'd0:    reg_dout = mask;
            2'd1:    reg_dout = pend;
            2'd2:    reg_dout = {irq_busy, irq, 3'b000, irq_vec};
            default: reg_dout = 8'h00;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Port rst  input  1  reset, synchronous, active-low (rst=0 resets on next clk edge).
REQ-003 Port irq_src  input  8  interrupt sources, synchronous to clk; bit 0 highest priority.
REQ-004 Port iack  input  1  acknowledge level from pipeline control FSM; high from IRQ state until RET state.
REQ-005 Port reg_we  input  1  register write strobe, one cycle per write.
REQ-006 Port reg_addr  input  2  register select: 0 MASK, 1 PEND, 2 STAT, 3 reserved.
REQ-007 Port reg_din  input  8  register write data.
REQ-008 Port reg_dout  output  8  combinational read data for reg_addr.
REQ-009 Port irq  output  1  interrupt request to control FSM; decoded from the state register only, glitch-free.
REQ-010 Port irq_vec  output  3  registered index of the source in service.
REQ-011 Port irq_busy  output  1  high while a source is in service.

Function
REQ-012 MASK: read/write; bit i=1 enables source i; a write takes effect on the next edge.
REQ-013 PEND: read returns pend; a write clears pend bits where reg_din=1 (W1C); a same-cycle set dominates the clear.
REQ-014 STAT: read returns {irq_busy, irq, 3'b000, irq_vec}; writes ignored; addr 3 reads 0, writes ignored.
REQ-015 act = pend & MASK; sel = lowest index i with act[i]=1.
REQ-016 FSM states: IDLE, REQ, SERV; irq=1 iff state=REQ.
REQ-017 IDLE: act!=0 -> REQ on next edge; iack ignored.
REQ-018 REQ: iack rising edge (iack=1, iack_d=0) -> SERV; irq_vec<=sel, irq_busy<=1, pend[sel] cleared, all in the same edge.
REQ-019 REQ: act becomes 0 (masked or W1C) before the iack rising edge -> IDLE, irq falls, vector unchanged.
REQ-020 REQ entered with iack already high: wait for iack to fall, then rise; no capture on a stale level.
REQ-021 SERV: iack falling edge -> IDLE, irq_busy<=0; irq_vec holds its last value.
REQ-022 No nesting: new source events during SERV only set pend; they are serviced after return to IDLE.
REQ-023 Latency: source event sampled at edge k -> pend set after edge k -> REQ/irq high after edge k+1.
REQ-024 After iack falls, any remaining act raises irq 2 edges later (IDLE then REQ).
REQ-025 Priority is re-evaluated at the iack edge, not at REQ entry; a higher-priority arrival while in REQ wins.

Reset
REQ-026 rst=0: state=IDLE, MASK=8'h00, pend=0, src_d=0, iack_d=0, irq=0, irq_vec=0, irq_busy=0.
REQ-027 Reset during REQ or SERV aborts the transaction with no capture; iack held high through reset release produces no capture.

Configuration
REQ-028 Macro IRQ_CTRL_EDGE_EN defined: pend[i] is set on the rising edge of irq_src[i] (irq_src & ~src_d), held until acknowledged or cleared by W1C.
REQ-029 IRQ_CTRL_EDGE_EN undefined: level mode; pend = irq_src combinationally, W1C and ack-clear have no effect, and irq rises after edge k (one edge sooner than REQ-023).

Verification
REQ-030 MASK=8'h01; pulse irq_src[0] one cycle at edge k -> PEND=8'h01 after k, irq=1 after k+1; iack rises -> irq_vec=0, busy=1, PEND=0, irq=0.
REQ-031 MASK=8'hFF; irq_src[5] and irq_src[2] rise together; ack -> irq_vec=2, PEND=8'h20; iack falls -> irq high 2 edges later; second ack -> irq_vec=5.
REQ-032 irq high for source 3; write MASK=8'h00 before iack -> IDLE, irq=0, PEND=8'h08 retained; write PEND=8'h08 -> PEND=0.
REQ-033 In SERV, pulse irq_src[1] -> PEND=8'h02, irq stays 0 until iack falls; then normal service with irq_vec=1.
REQ-034 irq high, drive rst=0 one edge while iack=1, then release with iack still 1 -> all outputs 0, MASK=0, no capture.
REQ-035 Level build: hold irq_src[4]=1, MASK=8'h10 -> irq after one edge; ack -> irq_vec=4, PEND still 8'h10; iack falls -> irq re-asserts.
